round_controller: RTL and testbench



---
 rtl/round_controller.sv | 206 ++++++++++++++++++++
 tb/tb_round_controller.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/round_controller.sv
// Match sequencer for the two-fighter game: round FSM, kick-hit detection,
// round-win scoring, health-bar lengths and player freeze / round-reset control.
module round_controller #(
  parameter int unsigned ROUNDS_TO_WIN = 3,
  parameter int unsigned INTRO_FRAMES  = 120,
  parameter int unsigned FREEZE_FRAMES = 60,
  parameter int unsigned ROUND_FRAMES  = 1800,
  parameter int unsigned OVER_FRAMES   = 180,
  parameter int unsigned FIGHTER_W     = 72,
  parameter int unsigned FIGHTER_H     = 105,
  parameter int unsigned BAR_LEN       = 144
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic       start,
  input  logic [2:0] p1_state,
  input  logic [2:0] p2_state,
  input  logic [9:0] fighter_X_Pos,
  input  logic [9:0] fighter_Y_Pos,
  input  logic [9:0] player2_X_Pos,
  input  logic [9:0] player2_Y_Pos,
  output logic [2:0] game_state,
  output logic       freeze,
  output logic       round_reset,
  output logic [1:0] p1_score,
  output logic [1:0] p2_score,
  output logic [2:0] last_event,
  output logic [1:0] winner,
  output logic [7:0] p1_bar_len,
  output logic [7:0] p2_bar_len
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_INTRO  = 3'd1,
    S_FIGHT  = 3'd2,
    S_FREEZE = 3'd3,
    S_OVER   = 3'd4
  } state_t;

  localparam logic [10:0] INTRO_LAST  = 11'(INTRO_FRAMES - 1);
  localparam logic [10:0] FREEZE_LAST = 11'(FREEZE_FRAMES - 1);
  localparam logic [10:0] ROUND_LAST  = 11'(ROUND_FRAMES - 1);
  localparam logic [10:0] OVER_MIN    = 11'(OVER_FRAMES);
  localparam logic [10:0] BOX_W       = 11'(FIGHTER_W);
  localparam logic [10:0] BOX_H       = 11'(FIGHTER_H);
  localparam logic [1:0]  WIN_SCORE   = 2'(ROUNDS_TO_WIN);
  localparam int unsigned BAR_STEP    = BAR_LEN / ROUNDS_TO_WIN;
  localparam logic [7:0]  BAR_FULL    = 8'(BAR_LEN);

  localparam logic [2:0] EV_NONE    = 3'd0;
  localparam logic [2:0] EV_P1      = 3'd1;
  localparam logic [2:0] EV_P2      = 3'd2;
  localparam logic [2:0] EV_DOUBLE  = 3'd3;
  localparam logic [2:0] EV_TIMEOUT = 3'd4;

  state_t      r_state;
  state_t      w_next;
  logic        r_freeze;
  logic        r_round_reset;

  logic        r_fclk_s1, r_fclk_s2, r_fclk_d, r_frame_tick;
  logic        r_start_s1, r_start_s2, r_start_d, r_start_pulse;

  logic [10:0] r_cnt;
  logic [1:0]  r_p1_score, r_p2_score;
  logic [2:0]  r_last_event;
  logic [1:0]  r_winner;
  logic [7:0]  r_p1_bar, r_p2_bar;

  logic [10:0] w_x1, w_y1, w_x2, w_y2, w_dx, w_dy;
  logic        w_overlap, w_hit1, w_hit2;
  logic        w_clear_match;
  logic [2:0]  w_event;
  logic        w_entry;

  // Widened to 11 bits so the absolute difference never wraps.
  assign w_x1 = {1'b0, fighter_X_Pos};
  assign w_y1 = {1'b0, fighter_Y_Pos};
  assign w_x2 = {1'b0, player2_X_Pos};
  assign w_y2 = {1'b0, player2_Y_Pos};
  assign w_dx = (w_x1 >= w_x2) ? (w_x1 - w_x2) : (w_x2 - w_x1);
  assign w_dy = (w_y1 >= w_y2) ? (w_y1 - w_y2) : (w_y2 - w_y1);
  assign w_overlap = (w_dx < BOX_W) && (w_dy < BOX_H);
  assign w_hit1 = w_overlap && (p1_state == 3'd2);
  assign w_hit2 = w_overlap && (p2_state == 3'd2);
  assign w_entry = (w_next != r_state);

  function automatic logic [7:0] bar_fill(input logic [1:0] opp_score);
    if (opp_score == WIN_SCORE) return '0;
    return 8'(BAR_LEN - 32'(opp_score) * BAR_STEP);
  endfunction

  always_comb begin
    w_next        = r_state;
    w_clear_match = 1'b0;
    w_event       = EV_NONE;
    case (r_state)
      S_IDLE: begin
        if (r_start_pulse) begin
          w_next        = S_INTRO;
          w_clear_match = 1'b1;
        end
      end
      S_INTRO: begin
        if (r_frame_tick && (r_cnt == INTRO_LAST)) w_next = S_FIGHT;
      end
      S_FIGHT: begin
        if (r_frame_tick) begin
          if (w_hit1 && w_hit2)       w_event = EV_DOUBLE;
          else if (w_hit1)            w_event = EV_P1;
          else if (w_hit2)            w_event = EV_P2;
          else if (r_cnt == ROUND_LAST) w_event = EV_TIMEOUT;
          if (w_event != EV_NONE) w_next = S_FREEZE;
        end
      end
      S_FREEZE: begin
        if (r_frame_tick && (r_cnt == FREEZE_LAST)) begin
          if ((r_p1_score == WIN_SCORE) || (r_p2_score == WIN_SCORE)) w_next = S_OVER;
          else                                                        w_next = S_INTRO;
        end
      end
      S_OVER: begin
        if (r_start_pulse && (r_cnt >= OVER_MIN)) begin
          w_next        = S_INTRO;
          w_clear_match = 1'b1;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state       <= S_IDLE;
      r_freeze      <= 1'b1;
      r_round_reset <= 1'b0;
    end else begin
      r_state       <= w_next;
      r_freeze      <= (w_next != S_FIGHT);
      r_round_reset <= (w_next == S_INTRO) && (r_state != S_INTRO);
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_fclk_s1     <= 1'b0;
      r_fclk_s2     <= 1'b0;
      r_fclk_d      <= 1'b0;
      r_frame_tick  <= 1'b0;
      r_start_s1    <= 1'b0;
      r_start_s2    <= 1'b0;
      r_start_d     <= 1'b0;
      r_start_pulse <= 1'b0;
      r_cnt         <= '0;
      r_p1_score    <= '0;
      r_p2_score    <= '0;
      r_last_event  <= EV_NONE;
      r_winner      <= '0;
      r_p1_bar      <= BAR_FULL;
      r_p2_bar      <= BAR_FULL;
    end else begin
      r_fclk_s1     <= frame_clk;
      r_fclk_s2     <= r_fclk_s1;
      r_fclk_d      <= r_fclk_s2;
      r_frame_tick  <= r_fclk_s2 & ~r_fclk_d;
      r_start_s1    <= start;
      r_start_s2    <= r_start_s1;
      r_start_d     <= r_start_s2;
      r_start_pulse <= r_start_s2 & ~r_start_d;

      // Saturate so a long MATCH_OVER wait cannot wrap back below OVER_MIN.
      if (w_entry)                             r_cnt <= '0;
      else if (r_frame_tick && (r_cnt != '1))  r_cnt <= r_cnt + 11'd1;

      if (w_clear_match) begin
        r_p1_score   <= '0;
        r_p2_score   <= '0;
        r_last_event <= EV_NONE;
        r_winner     <= '0;
      end else if (w_event != EV_NONE) begin
        r_last_event <= w_event;
        if ((w_event == EV_P1) && (r_p1_score != WIN_SCORE)) r_p1_score <= r_p1_score + 2'd1;
        if ((w_event == EV_P2) && (r_p2_score != WIN_SCORE)) r_p2_score <= r_p2_score + 2'd1;
      end

      if ((w_next == S_OVER) && (r_state != S_OVER))
        r_winner <= (r_p1_score == WIN_SCORE) ? 2'd1 : 2'd2;

      r_p1_bar <= bar_fill(r_p2_score);
      r_p2_bar <= bar_fill(r_p1_score);
    end
  end

  assign game_state  = r_state;
  assign freeze      = r_freeze;
  assign round_reset = r_round_reset;
  assign p1_score    = r_p1_score;
  assign p2_score    = r_p2_score;
  assign last_event  = r_last_event;
  assign winner      = r_winner;
  assign p1_bar_len  = r_p1_bar;
  assign p2_bar_len  = r_p2_bar;

endmodule

// File: tb/tb_round_controller.sv
// Directed bench for round_controller: round flow, hit/timeout scoring,
// health bars, match-over restart gating and mid-match reset.
module tb_round_controller;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_clk = 1'b0;
  logic       start = 1'b0;
  logic [2:0] p1_state = 3'd0;
  logic [2:0] p2_state = 3'd0;
  logic [9:0] fighter_X_Pos = 10'd100;
  logic [9:0] fighter_Y_Pos = 10'd300;
  logic [9:0] player2_X_Pos = 10'd400;
  logic [9:0] player2_Y_Pos = 10'd300;
  logic [2:0] game_state;
  logic       freeze;
  logic       round_reset;
  logic [1:0] p1_score, p2_score;
  logic [2:0] last_event;
  logic [1:0] winner;
  logic [7:0] p1_bar_len, p2_bar_len;

  int checks = 0;
  int failures = 0;
  int rr_cnt = 0;
  int rr_base = 0;

  round_controller #(
    .ROUNDS_TO_WIN(3),
    .INTRO_FRAMES (2),
    .FREEZE_FRAMES(2),
    .ROUND_FRAMES (5),
    .OVER_FRAMES  (3),
    .FIGHTER_W    (72),
    .FIGHTER_H    (105),
    .BAR_LEN      (144)
  ) dut (
    .Clk          (Clk),
    .Reset        (Reset),
    .frame_clk    (frame_clk),
    .start        (start),
    .p1_state     (p1_state),
    .p2_state     (p2_state),
    .fighter_X_Pos(fighter_X_Pos),
    .fighter_Y_Pos(fighter_Y_Pos),
    .player2_X_Pos(player2_X_Pos),
    .player2_Y_Pos(player2_Y_Pos),
    .game_state   (game_state),
    .freeze       (freeze),
    .round_reset  (round_reset),
    .p1_score     (p1_score),
    .p2_score     (p2_score),
    .last_event   (last_event),
    .winner       (winner),
    .p1_bar_len   (p1_bar_len),
    .p2_bar_len   (p2_bar_len)
  );

  always #10 Clk = ~Clk;

  always @(negedge Clk) if (round_reset === 1'b1) rr_cnt++;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One full frame_clk period; the tick and its registered effects settle inside.
  task automatic frame;
    frame_clk = 1'b1;
    repeat (6) @(posedge Clk);
    frame_clk = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic press_start;
    start = 1'b1;
    repeat (10) @(posedge Clk);
    start = 1'b0;
    repeat (4) @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic set_pos(input logic [9:0] x1, input logic [2:0] s1,
                         input logic [9:0] x2, input logic [2:0] s2);
    fighter_X_Pos = x1;
    fighter_Y_Pos = 10'd300;
    player2_X_Pos = x2;
    player2_Y_Pos = 10'd300;
    p1_state = s1;
    p2_state = s2;
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("rst_state", 16'(game_state), 16'd0);
    check("rst_freeze", 16'(freeze), 16'd1);
    check("rst_round_reset", 16'(round_reset), 16'd0);
    check("rst_scores", 16'({p1_score, p2_score}), 16'd0);
    check("rst_last_event", 16'(last_event), 16'd0);
    check("rst_winner", 16'(winner), 16'd0);
    check("rst_p1_bar", 16'(p1_bar_len), 16'd144);
    check("rst_p2_bar", 16'(p2_bar_len), 16'd144);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    // 1: held start gives one INTRO entry, FIGHT after 2 ticks
    rr_base = rr_cnt;
    press_start;
    check("t1_rr_once", 16'(rr_cnt - rr_base), 16'd1);
    check("t1_intro", 16'(game_state), 16'd1);
    check("t1_intro_freeze", 16'(freeze), 16'd1);
    frame;
    check("t1_intro_after1", 16'(game_state), 16'd1);
    frame;
    check("t1_fight", 16'(game_state), 16'd2);
    check("t1_fight_freeze", 16'(freeze), 16'd0);

    // 2: P1 kick hit, with explicit 3-Clk tick latency check
    set_pos(10'd100, 3'd2, 10'd150, 3'd0);
    frame_clk = 1'b1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    check("t2_before_tick", 16'(game_state), 16'd2);
    @(posedge Clk);
    @(negedge Clk);
    check("t2_freeze_state", 16'(game_state), 16'd3);
    check("t2_freeze_flag", 16'(freeze), 16'd1);
    check("t2_p1_score", 16'(p1_score), 16'd1);
    check("t2_last_event", 16'(last_event), 16'd1);
    @(negedge Clk);
    check("t2_p2_bar", 16'(p2_bar_len), 16'd96);
    check("t2_p1_bar", 16'(p1_bar_len), 16'd144);
    frame_clk = 1'b0;
    repeat (4) @(negedge Clk);
    set_pos(10'd100, 3'd0, 10'd400, 3'd0);
    frame;
    check("t2_freeze_after1", 16'(game_state), 16'd3);
    rr_base = rr_cnt;
    frame;
    check("t2_intro", 16'(game_state), 16'd1);
    check("t2_rr_pulse", 16'(rr_cnt - rr_base), 16'd1);
    frame;
    frame;
    check("t2_fight2", 16'(game_state), 16'd2);

    // 3: double hit, then exact-width separation is no hit
    set_pos(10'd100, 3'd2, 10'd160, 3'd2);
    frame;
    check("t3_double_event", 16'(last_event), 16'd3);
    check("t3_scores", 16'({p1_score, p2_score}), 16'b0100);
    check("t3_freeze", 16'(game_state), 16'd3);
    set_pos(10'd100, 3'd0, 10'd400, 3'd0);
    repeat (4) frame;
    check("t3_fight3", 16'(game_state), 16'd2);
    set_pos(10'd100, 3'd2, 10'd172, 3'd2);
    frame;
    check("t3_dx72_nohit", 16'(game_state), 16'd2);
    check("t3_dx72_event", 16'(last_event), 16'd3);

    // 4: timeout on 5th FIGHT tick, then hit coinciding with timeout
    set_pos(10'd100, 3'd0, 10'd400, 3'd0);
    repeat (3) frame;
    check("t4_tick4_fight", 16'(game_state), 16'd2);
    frame;
    check("t4_timeout_event", 16'(last_event), 16'd4);
    check("t4_timeout_state", 16'(game_state), 16'd3);
    check("t4_timeout_scores", 16'({p1_score, p2_score}), 16'b0100);
    repeat (4) frame;
    check("t4_fight4", 16'(game_state), 16'd2);
    repeat (4) frame;
    set_pos(10'd100, 3'd2, 10'd150, 3'd0);
    frame;
    check("t4_hit_over_timeout", 16'(last_event), 16'd1);
    check("t4_p1_score2", 16'(p1_score), 16'd2);
    check("t4_p2_bar48", 16'(p2_bar_len), 16'd48);
    set_pos(10'd100, 3'd0, 10'd400, 3'd0);
    repeat (2) frame;
    check("t4_intro_not_over", 16'(game_state), 16'd1);
    repeat (2) frame;

    // 5: third P1 win ends the match; restart gated by OVER_FRAMES
    set_pos(10'd100, 3'd2, 10'd150, 3'd0);
    frame;
    check("t5_p1_score3", 16'(p1_score), 16'd3);
    check("t5_p2_bar0", 16'(p2_bar_len), 16'd0);
    set_pos(10'd100, 3'd0, 10'd400, 3'd0);
    repeat (2) frame;
    check("t5_over", 16'(game_state), 16'd4);
    check("t5_winner", 16'(winner), 16'd1);
    check("t5_over_freeze", 16'(freeze), 16'd1);
    press_start;
    check("t5_start_ignored0", 16'(game_state), 16'd4);
    repeat (2) frame;
    press_start;
    check("t5_start_ignored2", 16'(game_state), 16'd4);
    frame;
    rr_base = rr_cnt;
    press_start;
    check("t5_restart", 16'(game_state), 16'd1);
    check("t5_restart_rr", 16'(rr_cnt - rr_base), 16'd1);
    check("t5_restart_scores", 16'({p1_score, p2_score}), 16'd0);
    check("t5_restart_winner", 16'(winner), 16'd0);
    check("t5_restart_event", 16'(last_event), 16'd0);
    check("t5_restart_bar", 16'(p2_bar_len), 16'd144);

    // 6: two P2 wins, then reset in FIGHT
    repeat (2) frame;
    for (int r = 0; r < 2; r++) begin
      set_pos(10'd100, 3'd0, 10'd150, 3'd2);
      frame;
      set_pos(10'd100, 3'd0, 10'd400, 3'd0);
      repeat (4) frame;
    end
    check("t6_fight", 16'(game_state), 16'd2);
    check("t6_p2_score2", 16'(p2_score), 16'd2);
    check("t6_p2_event", 16'(last_event), 16'd2);
    check("t6_p1_bar48", 16'(p1_bar_len), 16'd48);
    Reset = 1'b1;
    @(negedge Clk);
    check("t6_rst_state", 16'(game_state), 16'd0);
    check("t6_rst_scores", 16'({p1_score, p2_score}), 16'd0);
    check("t6_rst_p1_bar", 16'(p1_bar_len), 16'd144);
    check("t6_rst_p2_bar", 16'(p2_bar_len), 16'd144);
    check("t6_rst_freeze", 16'(freeze), 16'd1);
    check("t6_rst_rr", 16'(round_reset), 16'd0);
    Reset = 1'b0;
    repeat (2) @(negedge Clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
